if_fetch: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core. Owns the program counter, issues word requests to instruction memory over a valid/ready request channel with a variable-latency response, and presents one fetched instruction at a time, with its PC, to the IF/ID pipeline register. Handles downstream stalls and control-flow redirects, including discarding responses that were in flight when a redirect arrived.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/if_fetch.sv | 122 ++++++++++++
 tb/tb_if_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the RISC-V core
//
// Purpose: holds the canonical NOP encoding and the fetch-stage state type.
// Contents:
//   NOP_INSTR      addi x0, x0, 0; placed on instr_out whenever the slot is empty
//   fetch_state_t  REQ / WAIT / DRAIN state of the instruction-fetch stage
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage with redirect and in-flight drop
//
// Purpose: owns the PC, issues one word request at a time to instruction
// memory, and presents fetched instructions with their PC to IF/ID.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   redirect_in, redirect_pc_in    control-flow redirect (wins over stall)
//   stall_in                       downstream cannot take the slot this cycle
//   imem_req_valid/addr/ready      request channel (valid is combinational)
//   imem_resp_valid/data           one response pulse per accepted request
//   instr_out, pc_out, valid_out   registered output slot
module if_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  fetch_pc;
  logic [31:0]  pend_pc;
  logic         slot_free;
  logic         req_fire;
  logic         resp_load;

  // The slot is free if it is empty or is being consumed this cycle; a
  // request is only issued then, so a response never meets an occupied slot.
  assign slot_free     = !valid_out || !stall_in;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign resp_load     = (state == WAIT) && imem_resp_valid && !redirect_in;
  assign imem_req_addr = fetch_pc;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A redirect while waiting without a response moves to
  // DRAIN so the stale response is swallowed before the new PC is fetched.
  always_comb begin
    state_nxt = state;
    case (state)
      REQ: begin
        if (req_fire) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid)  state_nxt = REQ;
        else if (redirect_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (imem_resp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  // Output logic: request valid is held low during reset and on a redirect
  // cycle, so the redirect target is requested no earlier than the next cycle.
  always_comb begin
    imem_req_valid = 1'b0;
    if (rst && (state == REQ) && slot_free && !redirect_in) begin
      imem_req_valid = 1'b1;
    end
  end

  // PC registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      if (redirect_in) begin
        fetch_pc <= redirect_pc_in & 32'hFFFF_FFFC;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (req_fire) begin
        pend_pc <= fetch_pc;
      end
    end
  end

  // Output slot: redirect clears, response loads, consume clears, else hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
      pc_out    <= 32'd0;
    end else if (redirect_in) begin
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
      pc_out    <= 32'd0;
    end else if (resp_load) begin
      valid_out <= 1'b1;
      instr_out <= imem_resp_data;
      pc_out    <= pend_pc;
    end else if (valid_out && !stall_in) begin
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
      pc_out    <= 32'd0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for the instruction-fetch stage
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        stall_in;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;

  if_fetch #(.RESET_PC(32'h00000000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .stall_in        (stall_in),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory model state
  int          mem_lat = 1;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'd0;

  // values sampled mid-cycle by tick()
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_vo;
  logic [31:0] s_instr;
  logic [31:0] s_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'h00100113;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present the memory response, sample just after the
  // inputs settle, record an accepted request, then advance to the next negedge.
  task automatic tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memf(m_addr);
        m_pend = 1'b0;
      end
    end
    #1;
    s_req   = imem_req_valid;
    s_addr  = imem_req_addr;
    s_vo    = valid_out;
    s_instr = instr_out;
    s_pc    = pc_out;
    if (s_req && imem_req_ready) begin
      chk("one_outstanding", {31'd0, m_pend}, 32'd0);
      m_pend = 1'b1;
      m_cnt  = mem_lat;
      m_addr = s_addr;
    end
    @(negedge clk);
  endtask

  task automatic chk_slot(input string tag, input logic vo, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {31'd0, s_vo}, {31'd0, vo});
    chk({tag, "_pc"}, s_pc, pc);
    chk({tag, "_instr"}, s_instr, ins);
  endtask

  task automatic chk_req(input string tag, input logic rv, input logic [31:0] addr);
    chk({tag, "_req_valid"}, {31'd0, s_req}, {31'd0, rv});
    if (rv) chk({tag, "_req_addr"}, s_addr, addr);
  endtask

  logic [31:0] exp_pc;
  logic        p_vo, p_stall, p_redir;
  logic [31:0] p_pc;
  int          n_del;

  initial begin
    rst = 1'b0;
    redirect_in = 1'b0;
    redirect_pc_in = 32'd0;
    stall_in = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    @(negedge clk);

    // reset held for two cycles
    tick();
    tick();
    chk_slot("reset", 1'b0, 32'd0, NOP);
    chk_req("reset", 1'b0, 32'd0);

    // zero-wait memory
    rst = 1'b1;
    tick(); chk_req("first", 1'b1, 32'h0);
    tick(); chk_req("wait0", 1'b0, 32'h0); chk_slot("wait0", 1'b0, 32'd0, NOP);
    tick(); chk_slot("out0", 1'b1, 32'h0, 32'h00500093); chk_req("req4", 1'b1, 32'h4);
    tick(); chk_slot("gap", 1'b0, 32'd0, NOP);

    // stall for three cycles with a valid slot
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_slot("stall", 1'b1, 32'h4, 32'h00100113);
      chk_req("stall", 1'b0, 32'h0);
    end
    stall_in = 1'b0;
    tick(); chk_slot("release", 1'b1, 32'h4, 32'h00100113); chk_req("release", 1'b1, 32'h8);
    tick(); chk_slot("consumed", 1'b0, 32'd0, NOP);

    // latency 3, redirect while waiting -> drain
    mem_lat = 3;
    tick(); chk_slot("out8", 1'b1, 32'h8, memf(32'h8)); chk_req("reqc", 1'b1, 32'hC);
    redirect_in = 1'b1; redirect_pc_in = 32'h100;
    tick(); chk_req("redir_cycle", 1'b0, 32'h0);
    redirect_in = 1'b0;
    tick(); chk_req("drain1", 1'b0, 32'h0); chk_slot("drain1", 1'b0, 32'd0, NOP);
    tick(); chk_req("drain_resp", 1'b0, 32'h0); chk_slot("drain_resp", 1'b0, 32'd0, NOP);
    tick(); chk_req("req100", 1'b1, 32'h100); chk_slot("after_drain", 1'b0, 32'd0, NOP);
    mem_lat = 1;
    tick(); tick(); tick();
    tick(); chk_slot("out100", 1'b1, 32'h100, memf(32'h100)); chk_req("req104", 1'b1, 32'h104);

    // redirect in the same cycle as the response
    redirect_in = 1'b1; redirect_pc_in = 32'h200;
    tick(); chk_req("redir_resp", 1'b0, 32'h0);
    redirect_in = 1'b0;
    tick(); chk_slot("dropped", 1'b0, 32'd0, NOP); chk_req("req200", 1'b1, 32'h200);
    tick(); chk_slot("wait200", 1'b0, 32'd0, NOP);

    // redirect while stalled with a valid slot; unaligned target
    stall_in = 1'b1;
    tick(); chk_slot("out200", 1'b1, 32'h200, memf(32'h200)); chk_req("stall200", 1'b0, 32'h0);
    redirect_in = 1'b1; redirect_pc_in = 32'h302;
    tick(); chk_slot("redir_stall", 1'b1, 32'h200, memf(32'h200));
    redirect_in = 1'b0;
    tick(); chk_slot("cleared", 1'b0, 32'd0, NOP); chk_req("req300", 1'b1, 32'h300);
    tick();
    stall_in = 1'b0; mem_lat = 3;
    tick(); chk_slot("out300", 1'b1, 32'h300, memf(32'h300)); chk_req("req304", 1'b1, 32'h304);

    // reset during WAIT, stale response arrives afterwards
    rst = 1'b0;
    tick(); chk_req("in_reset", 1'b0, 32'h0);
    rst = 1'b1; imem_req_ready = 1'b0;
    tick(); chk_slot("post_reset", 1'b0, 32'd0, NOP); chk_req("post_reset", 1'b1, 32'h0);
    tick(); chk_slot("stale_resp", 1'b0, 32'd0, NOP);
    imem_req_ready = 1'b1; mem_lat = 1;
    tick(); chk_slot("ignored", 1'b0, 32'd0, NOP); chk_req("req_reset_pc", 1'b1, 32'h0);
    tick();
    tick(); chk_slot("refetch0", 1'b1, 32'h0, 32'h00500093);

    // randomized phase against a program-order model
    redirect_in = 1'b1; redirect_pc_in = 32'h1000;
    tick();
    exp_pc = 32'h1000;
    redirect_in = 1'b0;
    p_vo = s_vo; p_pc = s_pc; p_stall = stall_in; p_redir = 1'b1;
    n_del = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_in       = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      redirect_in    = ($urandom_range(0, 40) == 0);
      redirect_pc_in = $urandom;
      mem_lat        = $urandom_range(1, 4);
      tick();
      if (p_vo && p_stall && !p_redir) begin
        chk("rnd_hold_valid", {31'd0, s_vo}, 32'd1);
        chk("rnd_hold_pc", s_pc, p_pc);
      end
      if (!s_vo) begin
        chk("rnd_empty_instr", s_instr, NOP);
        chk("rnd_empty_pc", s_pc, 32'd0);
      end
      if (s_vo && !stall_in && !redirect_in) begin
        chk("rnd_pc", s_pc, exp_pc);
        chk("rnd_instr", s_instr, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      if (redirect_in) exp_pc = redirect_pc_in & 32'hFFFF_FFFC;
      p_vo = s_vo; p_pc = s_pc; p_stall = stall_in; p_redir = redirect_in;
    end
    chk("rnd_progress", {31'd0, (n_del > 100)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
